framebuffer_row_reader: RTL and testbench

// Read-side sequencer for the multimem dual-port frame buffer. On a start pulse it

---
 rtl/framebuffer_row_reader.sv | 147 ++++++++++++++
 tb/tb_framebuffer_row_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_row_reader.sv
// framebuffer_row_reader: walks port B of the dual-port frame buffer across one
// display row and streams the words out over a valid/ready interface.
//
// Handshake: a word transfers on a rising clk edge where out_valid && out_ready.
// Once out_valid is high, out_data and out_last hold steady until that transfer
// happens.
//
// The RAM returns a word one cycle after a read is issued. A two-entry skid FIFO
// absorbs that latency. A read is issued only when the word it returns is sure
// to find a free FIFO slot. That check counts the read already in flight and
// any pop happening on the same edge.
module framebuffer_row_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int COL_W  = 5,
    parameter int ROW_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  row_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clk_enable,
    output logic              ram_reset,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};

    state_t             state;
    state_t             state_nxt;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               inflight;
    logic               inflight_last;
    logic               done_q;

    logic [DATA_W-1:0]  fifo_data [2];
    logic [1:0]         fifo_last;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;

    logic               push;
    logic               pop;
    logic               issue;
    logic               col_end;
    logic [2:0]         occ_after;

    assign push      = inflight;
    assign pop       = (count != 2'd0) && out_ready;
    assign col_end   = (col == COL_MAX);
    // FIFO occupancy after this edge, excluding any read issued now.
    assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    // Next-state logic and the read-issue decision.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_READ;
            end
            S_READ: begin
                if ((count != 2'd2) && (occ_after < 3'd2)) begin
                    issue = 1'b1;
                    if (col_end) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last[rd_ptr]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, row/column walker, in-flight read tracking and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            row           <= '0;
            col           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == S_DRAIN) && pop && fifo_last[rd_ptr];
            if (state == S_IDLE && start) begin
                row <= row_sel;
                col <= '0;
            end
            inflight      <= issue;
            inflight_last <= issue && col_end;
            // The column stops at the last word so the address never wraps into the next row.
            if (issue && !col_end) col <= col + 1'b1;
        end
    end

    // Two-entry skid FIFO. A push and a pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ram_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign busy           = (state != S_IDLE);
    assign done           = done_q;
    assign ram_address    = {row, col};
    assign ram_clk_enable = issue;
    assign ram_reset      = 1'b0;
    assign out_data       = fifo_data[rd_ptr];
    assign out_valid      = (count != 2'd0);
    assign out_last       = out_valid && fifo_last[rd_ptr];
    assign fsm_state      = state;

endmodule

// File: tb/tb_framebuffer_row_reader.sv
// Bench for framebuffer_row_reader.
// It contains a behavioural port-B RAM, a scoreboard of expected words per row,
// a table of row runs and hand-written corner-case sequences.
module tb_framebuffer_row_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  row_sel;
    logic        busy;
    logic        done;
    logic [10:0] ram_address;
    logic        ram_clk_enable;
    logic        ram_reset;
    logic [15:0] ram_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  fsm_state;

    framebuffer_row_reader dut (
        .clk(clk), .reset(reset), .start(start), .row_sel(row_sel),
        .busy(busy), .done(done), .ram_address(ram_address),
        .ram_clk_enable(ram_clk_enable), .ram_reset(ram_reset),
        .ram_data(ram_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .fsm_state(fsm_state)
    );

    // Clock and RAM model.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] mem [0:2047];

    function automatic logic [15:0] exp_word(input int addr);
        return 16'h4241 + 16'(addr * 32'h0202);
    endfunction

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = exp_word(a);
        ram_data = 16'h0000;
    end

    always @(posedge clk) if (ram_clk_enable) ram_data <= mem[ram_address];

    // Scoreboard state and counters.
    int          total = 0;
    int          bad = 0;
    logic [16:0] exp_q[$];
    int          issued = 0;
    int          popped = 0;
    int          exp_col = 0;
    logic [5:0]  cur_row = 6'd0;
    int          ready_mode = 0;
    logic        stall_hold = 1'b0;
    logic [16:0] stall_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready driver. Modes: 0 hold high, 1 toggle, 2 random, 3 hold low.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks output words, stall stability, read addresses and FIFO headroom.
    always @(negedge clk) begin
        logic        hs;
        logic [16:0] e;
        if (!reset) begin
            stall_hold = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            if (stall_hold && out_valid)
                chk("stall_stable", 32'({out_last, out_data}), 32'(stall_word));
            stall_hold = out_valid && !out_ready;
            stall_word = {out_last, out_data};
            if (ram_clk_enable) begin
                chk("ram_address", 32'(ram_address), 32'({cur_row, 5'(exp_col)}));
                chk("col_in_row", 32'(exp_col < 32), 32'd1);
                chk("ce_while_full", 32'((issued - popped - int'(hs)) < 2), 32'd1);
                exp_col++;
                issued++;
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'({out_last, out_data}), 32'h1FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 32'({out_last, out_data}), 32'(e));
                end
                popped++;
            end
        end
    end

    // Driver tasks.
    task automatic start_row(input logic [5:0] row, input bit immediate);
        if (!immediate) @(negedge clk);
        start   = 1'b1;
        row_sel = row;
        cur_row = row;
        exp_col = 0;
        issued  = 0;
        popped  = 0;
        for (int c = 0; c < 32; c++)
            exp_q.push_back({c == 31, exp_word(int'(row) * 32 + c)});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input int exp_first);
        int cycles = 0;
        int first = -1;
        bit got = 0;
        while (cycles < 400 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (first < 0 && out_valid) first = cycles;
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            if (exp_lat > 0)   chk("row_latency", 32'(cycles), 32'(exp_lat));
            if (exp_first > 0) chk("first_valid", 32'(first), 32'(exp_first));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            chk("issue_count", 32'(issued), 32'd32);
        end
    endtask

    typedef struct {
        logic [5:0] row;
        int         mode;
        int         exp_lat;
        int         exp_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{row: 6'd0,  mode: 0, exp_lat: 34, exp_first: 2};
        vecs[1] = '{row: 6'd63, mode: 0, exp_lat: 34, exp_first: 2};
        vecs[2] = '{row: 6'd17, mode: 1, exp_lat: -1, exp_first: 2};
        vecs[3] = '{row: 6'd42, mode: 2, exp_lat: -1, exp_first: 2};
        vecs[4] = '{row: 6'd1,  mode: 0, exp_lat: 34, exp_first: 2};

        reset   = 1'b0;
        start   = 1'b0;
        row_sel = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_ce", 32'(ram_clk_enable), 32'd0);
        chk("rst_ram_reset", 32'(ram_reset), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven row runs under different out_ready patterns.
        for (int i = 0; i < 5; i++) begin
            ready_mode = vecs[i].mode;
            start_row(vecs[i].row, 1'b0);
            wait_done(vecs[i].exp_lat, vecs[i].exp_first);
            @(posedge clk);
            #1 chk("done_one_cycle", 32'(done), 32'd0);
        end

        // Downstream stalled from the start: exactly two reads, then the enable stays low.
        ready_mode = 3;
        repeat (2) @(posedge clk);
        start_row(6'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_issued", 32'(issued), 32'd2);
        chk("stall_ce_low", 32'(ram_clk_enable), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_head", 32'(out_data), 32'(exp_word(5 * 32)));
        ready_mode = 0;
        wait_done(-1, -1);

        // A start while busy is ignored; a start in the done cycle runs back to back.
        start_row(6'd7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        row_sel = 6'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(-1, -1);
        start_row(6'd10, 1'b1);
        wait_done(34, 2);

        // Reset mid-row aborts at once with no done pulse; then the whole row reruns.
        start_row(6'd20, 1'b0);
        begin
            int n = 0;
            while (popped < 10 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("reach_word10", 32'(popped >= 10), 32'd1);
        end
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ce", 32'(ram_clk_enable), 32'd0);
        chk("abort_addr", 32'(ram_address), 32'd0);
        chk("abort_data", 32'(out_data), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        exp_q.delete();
        issued = 0;
        popped = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk("abort_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        start_row(6'd20, 1'b0);
        wait_done(34, 2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
